axi_read_arbiter: RTL and testbench
===================================

# axi_read_arbiter

Read-address-phase arbiter and transaction sequencer for the 3-master, 8-slave AXI interconnect. It round-robin arbitrates ARVALID from M0–M2 and decodes the winner's address to a slave. It forwards the address handshake, then holds the master/slave pairing on `AR_arbiter` until the last read beat completes. `AR_arbiter` is the select code consumed by the read-data channel mux; one read transaction is in flight on the bus at a time.

## Interface
Parameters:
- `NUM_M`, 3: number of masters (fixed by encoding).
- `NUM_S`, 8: number of slaves (fixed by encoding).

Ports:
- `ACLK`  in  1  bus clock.
- `ARESET`  in  1  reset; one clock, asynchronous, active-high.
- `ARVALID_M`  in  [2:0]  per-master address valid.
- `ARREADY_M`  out  [2:0]  per-master address ready.
- `ARADDR_M`  in  [2:0][31:0]  per-master address.
- `ARID_M`  in  [2:0][3:0]  per-master ID.
- `ARLEN_M` / `ARSIZE_M` / `ARBURST_M`  in  [2:0][3:0] / [2:0][2:0] / [2:0][1:0]  burst attributes.
- `ARVALID_S`  out  [7:0]  per-slave address valid.
- `ARREADY_S`  in  [7:0]  per-slave address ready.
- `ARADDR_S` / `ARLEN_S` / `ARSIZE_S` / `ARBURST_S`  out  32/4/3/2  granted master's fields, broadcast to all slaves.
- `ARID_S`  out  8  {4'(master index), ARID}.
- `RVALID_S`, `RLAST_S`  in  [7:0]  slave read-data status, used for completion detection.
- `RREADY_M`  in  [2:0]  master read-data ready.
- `AR_arbiter`  out  6  pairing code: [5:4] master (3 = none), [3:0] slave (0–7, 8 = NO/unmapped).

## Operation
- FSM states:
  - IDLE (code 6'h3F).
  - ADDR (address handshake pending).
  - DATA (burst in progress).
- IDLE:
  - If any `ARVALID_M` is set, select a winner m by round-robin starting at `last+1` mod 3.
  - Register m, and register s = `decode_slave(ARADDR_M[m])`.
  - Go to ADDR. The code becomes {m, s}.
- ADDR:
  - `ARVALID_S[phys(s)] = ARVALID_M[m]` and `ARREADY_M[m] = ARREADY_S[phys(s)]`. All other valid/ready outputs are 0.
  - The payload is muxed combinationally from master m.
  - On `ARVALID_M[m] & ARREADY_S[phys(s)]`, go to DATA.
- DATA:
  - All `ARVALID_S` and `ARREADY_M` are 0.
  - On `RVALID_S[phys(s)] & RLAST_S[phys(s)] & RREADY_M[m]`, set `last = m` and go to IDLE.
- `phys(s)` is s for 0–7. For s = 8 (unmapped) it is 0: S0 is the default slave and returns DECERR.
- Address map (inclusive ranges):
  - S0: 0x0000_0000–0x0000_3FFF.
  - S1: 0x0001_0000–0x0001_FFFF.
  - S2: 0x0002_0000–0x0002_FFFF.
  - S3: 0x1000_0000–0x1000_03FF.
  - S4: 0x1001_0000–0x1001_03FF.
  - S5: 0x1002_0000–0x1002_03FF.
  - S6: 0x1003_0000–0x1003_03FF.
  - S7: 0x2000_0000–0x201F_FFFF.
  - Anything else maps to 8.
- Requests arriving in ADDR or DATA are not acknowledged; they wait for IDLE.
- Simultaneous requests in IDLE: the first requester at or after `last+1` wins.
- Illegal `ARVALID_M[m]` drop in ADDR: `ARVALID_S` follows it low, and the FSM stays in ADDR.

## Timing
- Reset (async assert; release synchronous to `ACLK`):
  - State IDLE; `AR_arbiter` = 6'h3F.
  - `last` = 2, so M0 has highest priority after reset.
  - `ARREADY_M`, `ARVALID_S` = 0; payload outputs 0.
- Grant latency: request sampled in IDLE at edge k. `ARVALID_S` is asserted after edge k, so the slave sees it in cycle k+1. No combinational path from `ARVALID_M` to `ARVALID_S` in IDLE.
- `ARREADY_M` is combinational from `ARREADY_S` in ADDR, with zero added latency.
- `AR_arbiter` is registered. It is stable from ADDR entry through the cycle of the last R handshake, then 6'h3F.
- Re-arbitration needs one IDLE cycle, so back-to-back transactions are separated by at least one cycle.
- Reset mid-ADDR or mid-DATA aborts to IDLE immediately. No handshake completes in the reset cycle.
- Single-beat burst (ARLEN = 0): DATA exits on that beat's handshake.

## Structure
- Package `axi_arb_pkg` holds:
  - FSM state enum.
  - `MX_SX_ID_BITS` = 6, `AR_IDLE_CODE` = 6'h3F, `SLAVE_NO` = 4'd8.
  - Address-map base/limit constants and function `decode_slave`.
- Sub-module `rr_arbiter3`: combinational round-robin picker taking `last` and the request vector, returning the winner index and a valid flag.
- All other logic lives in `axi_read_arbiter`.

## Test plan
- Reset then M1 reads 0x0001_0040, ARLEN = 3:
  - `ARVALID_S[1]` is asserted in the cycle after the request.
  - `AR_arbiter` = 6'h11 through 4 beats, then 6'h3F.
  - `ARID_S` = 8'h1_ID.
- M0, M1, M2 request together from reset:
  - Grant order is M0, M1, M2, with `AR_arbiter` [5:4] = 0, 1, 2 across three transactions.
  - The next M0 request wins only after M2 completes.
- M2 reads 0x3000_0000 (unmapped):
  - `AR_arbiter` = 6'h28.
  - `ARVALID_S[0]` is asserted and the S0 handshake completes.
  - Returns to IDLE on the S0 RLAST beat.
- M0 in DATA (S2, ARLEN = 7) while M1 asserts ARVALID:
  - `ARREADY_M[1]` stays 0 until M0's 8th beat handshakes with `RREADY_M[0] = 1`.
  - M1 is granted one IDLE cycle later.
- `RREADY_M` back-pressure: `RVALID_S & RLAST_S` held with `RREADY_M[m] = 0` for 3 cycles. The state stays DATA and exits only on the ready cycle.
- `ARESET` pulsed mid-DATA:
  - All outputs return to their reset values asynchronously.
  - The next request goes to M0 priority.

Source files
------------

// File: rtl/axi_arb_pkg.sv
// Shared types, constants and address decode for the AXI read-address arbiter.
package axi_arb_pkg;

    localparam int unsigned MX_SX_ID_BITS = 6;
    localparam int unsigned MAP_ENTRIES   = 8;

    localparam logic [MX_SX_ID_BITS-1:0] AR_IDLE_CODE = 6'h3F;
    localparam logic [3:0]               SLAVE_NO     = 4'd8;

    typedef enum logic [1:0] {
        AR_IDLE = 2'd0,
        AR_ADDR = 2'd1,
        AR_DATA = 2'd2
    } ar_state_e;

    typedef struct packed {
        logic [31:0] addr;
        logic [3:0]  id;
        logic [3:0]  len;
        logic [2:0]  size;
        logic [1:0]  burst;
    } ar_payload_t;

    // Inclusive base/limit per slave; index equals slave number.
    localparam logic [31:0] SLV_BASE [MAP_ENTRIES] = '{
        32'h0000_0000, 32'h0001_0000, 32'h0002_0000, 32'h1000_0000,
        32'h1001_0000, 32'h1002_0000, 32'h1003_0000, 32'h2000_0000
    };
    localparam logic [31:0] SLV_LIMIT [MAP_ENTRIES] = '{
        32'h0000_3FFF, 32'h0001_FFFF, 32'h0002_FFFF, 32'h1000_03FF,
        32'h1001_03FF, 32'h1002_03FF, 32'h1003_03FF, 32'h201F_FFFF
    };

    // Returns the slave index for an address, or SLAVE_NO when unmapped.
    function automatic logic [3:0] decode_slave(input logic [31:0] addr);
        logic [3:0] s;
        s = SLAVE_NO;
        for (int unsigned i = 0; i < MAP_ENTRIES; i++) begin
            if ((addr >= SLV_BASE[i]) && (addr <= SLV_LIMIT[i])) begin
                s = 4'(i);
            end
        end
        return s;
    endfunction

endpackage

// File: rtl/axi_read_arbiter_if.sv
// Read-address and read-status signals between masters, slaves and the arbiter.
interface axi_read_arbiter_if;
    import axi_arb_pkg::*;

    logic [2:0]       ARVALID_M;
    logic [2:0]       ARREADY_M;
    logic [2:0][31:0] ARADDR_M;
    logic [2:0][3:0]  ARID_M;
    logic [2:0][3:0]  ARLEN_M;
    logic [2:0][2:0]  ARSIZE_M;
    logic [2:0][1:0]  ARBURST_M;

    logic [7:0]       ARVALID_S;
    logic [7:0]       ARREADY_S;
    logic [31:0]      ARADDR_S;
    logic [3:0]       ARLEN_S;
    logic [2:0]       ARSIZE_S;
    logic [1:0]       ARBURST_S;
    logic [7:0]       ARID_S;

    logic [7:0]       RVALID_S;
    logic [7:0]       RLAST_S;
    logic [2:0]       RREADY_M;

    logic [MX_SX_ID_BITS-1:0] AR_arbiter;

    // Arbiter side: drives the slave-facing address channel and the pairing code.
    modport master (
        input  ARVALID_M, ARADDR_M, ARID_M, ARLEN_M, ARSIZE_M, ARBURST_M,
        input  ARREADY_S, RVALID_S, RLAST_S, RREADY_M,
        output ARREADY_M, ARVALID_S, ARADDR_S, ARLEN_S, ARSIZE_S, ARBURST_S,
        output ARID_S, AR_arbiter
    );

    // Environment side: masters and slaves attached to the arbiter.
    modport slave (
        output ARVALID_M, ARADDR_M, ARID_M, ARLEN_M, ARSIZE_M, ARBURST_M,
        output ARREADY_S, RVALID_S, RLAST_S, RREADY_M,
        input  ARREADY_M, ARVALID_S, ARADDR_S, ARLEN_S, ARSIZE_S, ARBURST_S,
        input  ARID_S, AR_arbiter
    );

endinterface

// File: rtl/rr_arbiter3.sv
// Combinational three-way round-robin picker; the master after `last` has top priority.
module rr_arbiter3 (
    input  logic [1:0] last,
    input  logic [2:0] req,
    output logic [1:0] grant,
    output logic       valid
);

    logic [1:0] p0, p1, p2;

    always_comb begin
        p0    = 2'd0;
        p1    = 2'd1;
        p2    = 2'd2;
        grant = 2'd0;
        valid = |req;

        case (last)
            2'd0:    begin p0 = 2'd1; p1 = 2'd2; p2 = 2'd0; end
            2'd1:    begin p0 = 2'd2; p1 = 2'd0; p2 = 2'd1; end
            default: begin p0 = 2'd0; p1 = 2'd1; p2 = 2'd2; end
        endcase

        if (req[p0]) begin
            grant = p0;
        end else if (req[p1]) begin
            grant = p1;
        end else begin
            grant = p2;
        end
    end

endmodule

// File: rtl/axi_read_arbiter.sv
// Read-address arbiter: round-robin grant, address decode, and master/slave pairing
// held on AR_arbiter until the last read beat of the transaction completes.
module axi_read_arbiter
    import axi_arb_pkg::*;
#(
    parameter int unsigned NUM_M = 3,
    parameter int unsigned NUM_S = 8
) (
    input logic                 ACLK,
    input logic                 ARESET,
    axi_read_arbiter_if.master  bus
);

    ar_state_e                state_q, state_d;
    logic [MX_SX_ID_BITS-1:0] code_q, code_d;
    logic [1:0]               last_q, last_d;

    logic [1:0]       rr_grant;
    logic             rr_valid;
    logic [1:0]       m_sel;
    logic [3:0]       s_sel;
    logic [2:0]       s_phys;
    logic [NUM_M-1:0] m_oh;
    logic [NUM_S-1:0] s_oh;
    logic             m_arvalid;
    logic             s_arready;
    logic             r_last_hs;
    ar_payload_t      pay;

    rr_arbiter3 u_rr (
        .last  (last_q),
        .req   (bus.ARVALID_M),
        .grant (rr_grant),
        .valid (rr_valid)
    );

    // Unmapped addresses are routed to S0, which answers with DECERR.
    assign m_sel  = code_q[5:4];
    assign s_sel  = code_q[3:0];
    assign s_phys = (s_sel == SLAVE_NO) ? 3'd0 : s_sel[2:0];

    // Master index 3 (idle) shifts out of range and yields an all-zero select.
    assign m_oh = NUM_M'(1) << m_sel;
    assign s_oh = NUM_S'(1) << s_phys;

    assign m_arvalid = |(bus.ARVALID_M & m_oh);
    assign s_arready = |(bus.ARREADY_S & s_oh);
    assign r_last_hs = (|(bus.RVALID_S & bus.RLAST_S & s_oh)) & (|(bus.RREADY_M & m_oh));

    // Payload of the paired master.
    always_comb begin
        pay = '0;
        if (m_sel != 2'd3) begin
            pay.addr  = bus.ARADDR_M[m_sel];
            pay.id    = bus.ARID_M[m_sel];
            pay.len   = bus.ARLEN_M[m_sel];
            pay.size  = bus.ARSIZE_M[m_sel];
            pay.burst = bus.ARBURST_M[m_sel];
        end
    end

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            state_q <= AR_IDLE;
            code_q  <= AR_IDLE_CODE;
            last_q  <= 2'd2;
        end else begin
            state_q <= state_d;
            code_q  <= code_d;
            last_q  <= last_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        code_d        = code_q;
        last_d        = last_q;
        bus.ARVALID_S = '0;
        bus.ARREADY_M = '0;
        bus.ARADDR_S  = '0;
        bus.ARLEN_S   = '0;
        bus.ARSIZE_S  = '0;
        bus.ARBURST_S = '0;
        bus.ARID_S    = '0;

        case (state_q)
            AR_IDLE: begin
                if (rr_valid) begin
                    state_d = AR_ADDR;
                    code_d  = {rr_grant, decode_slave(bus.ARADDR_M[rr_grant])};
                end
            end
            AR_ADDR: begin
                bus.ARVALID_S = s_oh & {NUM_S{m_arvalid}};
                bus.ARREADY_M = m_oh & {NUM_M{s_arready}};
                bus.ARADDR_S  = pay.addr;
                bus.ARLEN_S   = pay.len;
                bus.ARSIZE_S  = pay.size;
                bus.ARBURST_S = pay.burst;
                bus.ARID_S    = {2'b00, m_sel, pay.id};
                if (m_arvalid && s_arready) begin
                    state_d = AR_DATA;
                end
            end
            AR_DATA: begin
                if (r_last_hs) begin
                    state_d = AR_IDLE;
                    code_d  = AR_IDLE_CODE;
                    last_d  = m_sel;
                end
            end
            default: begin
                state_d = AR_IDLE;
                code_d  = AR_IDLE_CODE;
            end
        endcase
    end

    assign bus.AR_arbiter = code_q;

endmodule

// File: tb/tb_axi_read_arbiter.sv
// Directed bench for axi_read_arbiter: grant order, decode, pairing hold and reset abort.
module tb_axi_read_arbiter;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;

    axi_read_arbiter_if bus ();

    axi_read_arbiter dut (
        .ACLK   (clk),
        .ARESET (rst),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
        total++;
        assert (obs === want) else begin
            bad++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, want);
        end
    endtask

    task automatic clear_inputs();
        bus.ARVALID_M = '0;
        bus.ARADDR_M  = '0;
        bus.ARID_M    = '0;
        bus.ARLEN_M   = '0;
        bus.ARSIZE_M  = '0;
        bus.ARBURST_M = '0;
        bus.ARREADY_S = '0;
        bus.RVALID_S  = '0;
        bus.RLAST_S   = '0;
        bus.RREADY_M  = '0;
    endtask

    task automatic request(input logic [1:0] m, input logic [31:0] addr,
                           input logic [3:0] id, input logic [3:0] len);
        bus.ARVALID_M[m] = 1'b1;
        bus.ARADDR_M[m]  = addr;
        bus.ARID_M[m]    = id;
        bus.ARLEN_M[m]   = len;
        bus.ARSIZE_M[m]  = 3'd2;
        bus.ARBURST_M[m] = 2'd1;
    endtask

    // Entered just after the negedge of the first ADDR cycle; leaves in DATA.
    task automatic addr_phase(input logic [1:0] m, input logic [2:0] ph,
                              input logic [5:0] code, input string tag);
        logic [7:0] exp_s;
        logic [2:0] exp_m;
        exp_s = 8'h01 << ph;
        exp_m = 3'b001 << m;
        #1;
        chk({tag, "_code"}, 32'(bus.AR_arbiter), 32'(code));
        chk({tag, "_arvalid_s"}, 32'(bus.ARVALID_S), 32'(exp_s));
        chk({tag, "_arready_m_wait"}, 32'(bus.ARREADY_M), 32'h0);
        bus.ARREADY_S[ph] = 1'b1;
        #1;
        chk({tag, "_arready_m"}, 32'(bus.ARREADY_M), 32'(exp_m));
        @(negedge clk);
        bus.ARVALID_M[m] = 1'b0;
        bus.ARREADY_S    = '0;
        #1;
        chk({tag, "_data_arvalid_s"}, 32'(bus.ARVALID_S), 32'h0);
    endtask

    // Drives `beats` R handshakes, RLAST on the final one; leaves in IDLE.
    task automatic data_phase(input logic [1:0] m, input logic [2:0] ph, input int beats,
                              input logic [5:0] code, input string tag);
        for (int b = 0; b < beats; b++) begin
            bus.RVALID_S[ph] = 1'b1;
            bus.RLAST_S[ph]  = (b == beats - 1);
            bus.RREADY_M[m]  = 1'b1;
            #1;
            chk({tag, "_beat_code"}, 32'(bus.AR_arbiter), 32'(code));
            chk({tag, "_beat_arready_m"}, 32'(bus.ARREADY_M), 32'h0);
            @(negedge clk);
        end
        bus.RVALID_S = '0;
        bus.RLAST_S  = '0;
        bus.RREADY_M = '0;
        #1;
        chk({tag, "_end_code"}, 32'(bus.AR_arbiter), 32'h3F);
        chk({tag, "_end_arready_m"}, 32'(bus.ARREADY_M), 32'h0);
    endtask

    initial begin
        clear_inputs();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_code", 32'(bus.AR_arbiter), 32'h3F);
        chk("rst_arvalid_s", 32'(bus.ARVALID_S), 32'h0);
        chk("rst_arready_m", 32'(bus.ARREADY_M), 32'h0);
        chk("rst_araddr_s", bus.ARADDR_S, 32'h0);
        chk("rst_arid_s", 32'(bus.ARID_S), 32'h0);
        rst = 1'b0;

        // Single master, 4-beat burst to S1.
        @(negedge clk);
        request(2'd1, 32'h0001_0040, 4'hA, 4'd3);
        #1;
        chk("t1_idle_no_comb", 32'(bus.ARVALID_S), 32'h0);
        chk("t1_idle_code", 32'(bus.AR_arbiter), 32'h3F);
        @(negedge clk);
        #1;
        chk("t1_arid_s", 32'(bus.ARID_S), 32'h1A);
        chk("t1_araddr_s", bus.ARADDR_S, 32'h0001_0040);
        chk("t1_arlen_s", 32'(bus.ARLEN_S), 32'd3);
        chk("t1_arsize_s", 32'(bus.ARSIZE_S), 32'd2);
        chk("t1_arburst_s", 32'(bus.ARBURST_S), 32'd1);
        addr_phase(2'd1, 3'd1, 6'h11, "t1");
        data_phase(2'd1, 3'd1, 4, 6'h11, "t1");

        // Three simultaneous requests from reset: M0, M1, M2, then M0 again.
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        request(2'd0, 32'h0000_0100, 4'h1, 4'd0);
        request(2'd1, 32'h0002_0000, 4'h2, 4'd0);
        request(2'd2, 32'h1000_0000, 4'h3, 4'd0);
        @(negedge clk);
        addr_phase(2'd0, 3'd0, 6'h00, "t2_m0");
        data_phase(2'd0, 3'd0, 1, 6'h00, "t2_m0");
        @(negedge clk);
        addr_phase(2'd1, 3'd2, 6'h12, "t2_m1");
        data_phase(2'd1, 3'd2, 1, 6'h12, "t2_m1");
        @(negedge clk);
        addr_phase(2'd2, 3'd3, 6'h23, "t2_m2");
        request(2'd0, 32'h0000_0200, 4'h4, 4'd0);
        data_phase(2'd2, 3'd3, 1, 6'h23, "t2_m2");
        @(negedge clk);
        addr_phase(2'd0, 3'd0, 6'h00, "t2_m0b");
        data_phase(2'd0, 3'd0, 1, 6'h00, "t2_m0b");

        // Unmapped address falls back to S0.
        request(2'd2, 32'h3000_0000, 4'h5, 4'd1);
        @(negedge clk);
        addr_phase(2'd2, 3'd0, 6'h28, "t3");
        data_phase(2'd2, 3'd0, 2, 6'h28, "t3");

        // M1 waits out M0's 8-beat burst.
        request(2'd0, 32'h0002_8000, 4'h6, 4'd7);
        @(negedge clk);
        addr_phase(2'd0, 3'd2, 6'h02, "t4_m0");
        request(2'd1, 32'h0001_0000, 4'h7, 4'd0);
        data_phase(2'd0, 3'd2, 8, 6'h02, "t4_m0");
        @(negedge clk);
        addr_phase(2'd1, 3'd1, 6'h11, "t4_m1");
        data_phase(2'd1, 3'd1, 1, 6'h11, "t4_m1");

        // Last beat held while the owning master is not ready.
        request(2'd2, 32'h1003_0010, 4'h8, 4'd0);
        @(negedge clk);
        addr_phase(2'd2, 3'd6, 6'h26, "t5");
        bus.RVALID_S[6] = 1'b1;
        bus.RLAST_S[6]  = 1'b1;
        bus.RREADY_M    = 3'b011;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("t5_stall_code", 32'(bus.AR_arbiter), 32'h26);
            @(negedge clk);
        end
        bus.RREADY_M = 3'b000;
        data_phase(2'd2, 3'd6, 1, 6'h26, "t5");

        // Address map edges.
        request(2'd2, 32'h1000_03FF, 4'h1, 4'd0);
        @(negedge clk);
        addr_phase(2'd2, 3'd3, 6'h23, "t6_s3_top");
        data_phase(2'd2, 3'd3, 1, 6'h23, "t6_s3_top");
        request(2'd1, 32'h201F_FFFF, 4'h9, 4'd0);
        @(negedge clk);
        addr_phase(2'd1, 3'd7, 6'h17, "t6_s7_top");
        data_phase(2'd1, 3'd7, 1, 6'h17, "t6_s7_top");
        request(2'd0, 32'h0000_4000, 4'h2, 4'd0);
        @(negedge clk);
        addr_phase(2'd0, 3'd0, 6'h08, "t6_s0_past");
        data_phase(2'd0, 3'd0, 1, 6'h08, "t6_s0_past");

        // Reset mid-DATA aborts, and M0 regains top priority.
        request(2'd1, 32'h1001_0000, 4'hB, 4'd3);
        @(negedge clk);
        addr_phase(2'd1, 3'd4, 6'h14, "t7");
        bus.RVALID_S[4] = 1'b1;
        bus.RREADY_M[1] = 1'b1;
        request(2'd0, 32'h0001_0000, 4'hC, 4'd0);
        request(2'd1, 32'h1001_0000, 4'hB, 4'd3);
        #1;
        chk("t7_in_data_code", 32'(bus.AR_arbiter), 32'h14);
        rst = 1'b1;
        #1;
        chk("t7_async_code", 32'(bus.AR_arbiter), 32'h3F);
        chk("t7_async_arvalid_s", 32'(bus.ARVALID_S), 32'h0);
        chk("t7_async_arready_m", 32'(bus.ARREADY_M), 32'h0);
        chk("t7_async_araddr_s", bus.ARADDR_S, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        bus.RVALID_S = '0;
        bus.RREADY_M = '0;
        @(negedge clk);
        addr_phase(2'd0, 3'd1, 6'h01, "t7_m0_after_rst");
        data_phase(2'd0, 3'd1, 1, 6'h01, "t7_m0_after_rst");
        bus.ARVALID_M = '0;
        @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
